// File: rtl/fib_job_arbiter.sv
// Round-robin front end that time-shares one Fibonacci engine among NUM_REQ requesters,
// bounding each job with a RUN-cycle timeout and returning the result over valid/ready.
module fib_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [5*NUM_REQ-1:0]   req_n,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [63:0]            rsp_result,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic                   eng_rst,
  output logic [4:0]             eng_n,
  input  logic                   eng_done,
  input  logic [63:0]            eng_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Returns {found, index} of the first set request at or above ptr, wrapping around.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = {(IDX_W+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (r[idx]) begin
        res = {1'b1, IDX_W'(idx)};
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] rr_advance(input logic [IDX_W-1:0] idx);
    return IDX_W'((int'(idx) + 1) % NUM_REQ);
  endfunction

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]     owner_r, owner_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [NUM_REQ-1:0]   ack_r, ack_s;
  logic [NUM_REQ-1:0]   rsp_valid_r, rsp_valid_s;
  logic [63:0]          rsp_result_r, rsp_result_s;
  logic                 rsp_timeout_r, rsp_timeout_s;
  logic                 busy_r, busy_s;
  logic                 eng_rst_r, eng_rst_s;
  logic [4:0]           eng_n_r, eng_n_s;
  logic [IDX_W:0]       pick_s;
  logic                 found_s;
  logic [IDX_W-1:0]     win_s;

  assign pick_s  = rr_pick(req, rr_ptr_r);
  assign found_s = pick_s[IDX_W];
  assign win_s   = pick_s[IDX_W-1:0];

  // Next-state and next-output logic for the IDLE/RUN/RESP job sequencer.
  always_comb begin
    state_s       = state_r;
    rr_ptr_s      = rr_ptr_r;
    owner_s       = owner_r;
    cnt_s         = cnt_r;
    ack_s         = {NUM_REQ{1'b0}};
    rsp_valid_s   = rsp_valid_r;
    rsp_result_s  = rsp_result_r;
    rsp_timeout_s = rsp_timeout_r;
    eng_rst_s     = eng_rst_r;
    eng_n_s       = eng_n_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          ack_s     = one_hot(win_s);
          eng_n_s   = req_n[int'(win_s)*5 +: 5];
          eng_rst_s = 1'b0;
          cnt_s     = {CNT_W{1'b0}};
          owner_s   = win_s;
          rr_ptr_s  = rr_advance(win_s);
          state_s   = ST_RUN;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_s = cnt_r + CNT_W'(1);
        // The engine's done is not trusted on the cycle it leaves reset.
        if ((cnt_r != {CNT_W{1'b0}}) && eng_done) begin
          rsp_result_s  = eng_result;
          rsp_timeout_s = 1'b0;
          rsp_valid_s   = one_hot(owner_r);
          eng_rst_s     = 1'b1;
          state_s       = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          rsp_result_s  = 64'd0;
          rsp_timeout_s = 1'b1;
          rsp_valid_s   = one_hot(owner_r);
          eng_rst_s     = 1'b1;
          state_s       = ST_RESP;
        end else begin
          state_s       = ST_RUN;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_r]) begin
          rsp_valid_s   = {NUM_REQ{1'b0}};
          rsp_timeout_s = 1'b0;
          state_s       = ST_IDLE;
        end else begin
          state_s       = ST_RESP;
        end
      end
      default: begin
        rsp_valid_s   = {NUM_REQ{1'b0}};
        rsp_timeout_s = 1'b0;
        eng_rst_s     = 1'b1;
        state_s       = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset holds the engine idle and drops any pending job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= {IDX_W{1'b0}};
      owner_r       <= {IDX_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      ack_r         <= {NUM_REQ{1'b0}};
      rsp_valid_r   <= {NUM_REQ{1'b0}};
      rsp_result_r  <= 64'd0;
      rsp_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
      eng_rst_r     <= 1'b1;
      eng_n_r       <= 5'd0;
    end else begin
      state_r       <= state_s;
      rr_ptr_r      <= rr_ptr_s;
      owner_r       <= owner_s;
      cnt_r         <= cnt_s;
      ack_r         <= ack_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_result_r  <= rsp_result_s;
      rsp_timeout_r <= rsp_timeout_s;
      busy_r        <= busy_s;
      eng_rst_r     <= eng_rst_s;
      eng_n_r       <= eng_n_s;
    end
  end

  assign ack         = ack_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = rsp_result_r;
  assign rsp_timeout = rsp_timeout_r;
  assign busy        = busy_r;
  assign eng_rst     = eng_rst_r;
  assign eng_n       = eng_n_r;

endmodule

// File: tb/tb_fib_job_arbiter.sv
// Directed bench for fib_job_arbiter: engine stub, job-level reference model checked every cycle,
// plus literal expectations for grants, results, latencies and reset behaviour.
module tb_fib_job_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [5*NR-1:0] req_n;
  logic [NR-1:0] ack;
  logic [NR-1:0] rsp_valid;
  logic [NR-1:0] rsp_ready;
  logic [63:0]   rsp_result;
  logic          rsp_timeout;
  logic          busy;
  logic          eng_rst;
  logic [4:0]    eng_n;
  logic          eng_done;
  logic [63:0]   eng_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fib_job_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout), .busy(busy), .eng_rst(eng_rst), .eng_n(eng_n),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Engine stub: done after a configurable number of cycles out of reset.
  int stub_cyc = 0;
  bit stub_never = 1'b0;
  int stub_lat = -1;     // -1: latency N+2
  bit stub_fib = 1'b0;   // 0: result N+100, 1: Fibonacci(N)
  int lat_eff;
  always @(posedge clk) begin
    if (eng_rst) stub_cyc <= 0;
    else         stub_cyc <= stub_cyc + 1;
  end
  assign lat_eff    = (stub_lat < 0) ? int'(eng_n) + 2 : stub_lat;
  assign eng_done   = !eng_rst && !stub_never && (stub_cyc >= lat_eff);
  assign eng_result = stub_fib ? fib(int'(eng_n)) : (64'(eng_n) + 64'd100);

  // Job-level reference model
  int          m_phase;   // 0 idle, 1 job running, 2 response pending
  int          m_ptr, m_owner, m_elapsed;
  logic [NR-1:0] m_ack, m_rsp_valid;
  logic [63:0] m_res;
  logic        m_tout, m_busy, m_eng_rst;
  logic [4:0]  m_eng_n;

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_owner = 0; m_elapsed = 0;
    m_ack = '0; m_rsp_valid = '0; m_res = 64'd0; m_tout = 1'b0;
    m_busy = 1'b0; m_eng_rst = 1'b1; m_eng_n = 5'd0;
  endtask

  task automatic model_advance();
    int w;
    m_ack = '0;
    if (m_phase == 0) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      if (w >= 0) begin
        m_ack[w] = 1'b1;
        m_eng_n = req_n[5*w +: 5];
        m_eng_rst = 1'b0;
        m_owner = w;
        m_ptr = (w + 1) % NR;
        m_elapsed = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if ((m_elapsed > 0 && eng_done) || m_elapsed == TO - 1) begin
        m_tout = !(m_elapsed > 0 && eng_done);
        m_res = m_tout ? 64'd0 : eng_result;
        m_rsp_valid = '0;
        m_rsp_valid[m_owner] = 1'b1;
        m_eng_rst = 1'b1;
        m_phase = 2;
      end else begin
        m_elapsed++;
      end
    end else begin
      if (rsp_ready[m_owner]) begin
        m_rsp_valid = '0;
        m_tout = 1'b0;
        m_phase = 0;
      end
    end
    m_busy = (m_phase != 0);
  endtask

  task automatic check_and_advance();
    if (!rst) model_reset();
    checks++;
    if (ack !== m_ack || rsp_valid !== m_rsp_valid || rsp_result !== m_res ||
        rsp_timeout !== m_tout || busy !== m_busy || eng_rst !== m_eng_rst || eng_n !== m_eng_n) begin
      errors++;
      $display("FAIL model cyc=%0d ack=%b/%b rsp_valid=%b/%b result=%0d/%0d timeout=%b/%b busy=%b/%b eng_rst=%b/%b eng_n=%0d/%0d (got/required)",
               cyc, ack, m_ack, rsp_valid, m_rsp_valid, rsp_result, m_res, rsp_timeout, m_tout,
               busy, m_busy, eng_rst, m_eng_rst, eng_n, m_eng_n);
    end
    if (rst) model_advance();
  endtask

  task automatic step();
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  int grant_q[$];
  int n_q[$];
  int lat_q[$];
  logic [63:0] res_q[$];
  int tout_q[$];

  task automatic clear_logs();
    grant_q.delete(); n_q.delete(); lat_q.delete(); res_q.delete(); tout_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; rsp_ready = '1;
    step(); step();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic set_req(input int i, input int n);
    req[i] = 1'b1;
    req_n[5*i +: 5] = 5'(n);
  endtask

  // Runs until njobs responses are handshaken; requesters drop req on ack unless hold.
  task automatic run_jobs(input int njobs, input bit hold);
    int done_jobs, budget, t_ack;
    bit armed;
    done_jobs = 0; budget = 0; t_ack = 0; armed = 1'b0;
    while (done_jobs < njobs && budget < 2000) begin
      step();
      budget++;
      if (ack != '0) begin
        grant_q.push_back(oh2idx(ack));
        n_q.push_back(int'(eng_n));
        t_ack = cyc;
        armed = 1'b1;
        if (!hold) req = req & ~ack;
      end
      if (rsp_valid != '0 && armed) begin
        lat_q.push_back(cyc - t_ack);
        armed = 1'b0;
      end
      if ((rsp_valid & rsp_ready) != '0) begin
        res_q.push_back(rsp_result);
        tout_q.push_back(int'(rsp_timeout));
        done_jobs++;
        if (done_jobs == njobs) req = '0;
      end
    end
    req = '0;
    chk("jobs_completed", 64'(done_jobs), 64'(njobs));
  endtask

  initial begin
    int budget;
    logic [63:0] held_res;
    rst = 1'b0; req = '0; req_n = '0; rsp_ready = '1;
    model_reset();

    // Reset values
    step(); step();
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_eng_rst", 64'(eng_rst), 64'd1);
    chk("rst_eng_n", 64'(eng_n), 64'd0);
    chk("fib_pin0", fib(0), 64'd0);
    chk("fib_pin10", fib(10), 64'd55);
    chk("fib_pin31", fib(31), 64'd1346269);
    rst = 1'b1;

    // Single requester 1, N=10
    set_req(1, 10);
    run_jobs(1, 1'b0);
    chk("single_grant", 64'(grant_q[0]), 64'd1);
    chk("single_eng_n", 64'(n_q[0]), 64'd10);
    chk("single_result", res_q[0], 64'd110);
    chk("single_timeout", 64'(tout_q[0]), 64'd0);
    chk("single_latency", 64'(lat_q[0]), 64'd13);

    // Requesters 0 and 2 together from rr_ptr=0, then probe rr_ptr with {0,1,3}
    do_reset();
    set_req(0, 3); set_req(2, 7);
    run_jobs(2, 1'b0);
    chk("pair_grant0", 64'(grant_q[0]), 64'd0);
    chk("pair_grant1", 64'(grant_q[1]), 64'd2);
    chk("pair_res0", res_q[0], 64'd103);
    chk("pair_res1", res_q[1], 64'd107);
    set_req(0, 1); set_req(1, 1); set_req(3, 1);
    run_jobs(1, 1'b0);
    chk("rr_ptr_probe", 64'(grant_q[2]), 64'd3);

    // All four held for eight jobs
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, i + 1);
    run_jobs(8, 1'b1);
    for (int j = 0; j < 8; j++) begin
      chk("rr_order", 64'(grant_q[j]), 64'(j % NR));
      chk("rr_result", res_q[j], 64'(j % NR + 1 + 100));
    end
    for (int j = 1; j < 8; j++) begin
      checks++;
      if (grant_q[j] == grant_q[j-1]) begin
        errors++;
        $display("FAIL rr_repeat job=%0d got=%0d required=not %0d", j, grant_q[j], grant_q[j-1]);
      end
    end

    // Response held while the owner is not ready; other ready bits must be ignored
    do_reset();
    rsp_ready = 4'b1011;
    set_req(2, 5);
    budget = 0;
    while (ack == '0 && budget < 50) begin step(); budget++; end
    chk("hold_ack", 64'(ack), 64'b0100);
    req = '0;
    budget = 0;
    while (rsp_valid == '0 && budget < 50) begin step(); budget++; end
    held_res = rsp_result;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("hold_valid", 64'(rsp_valid), 64'b0100);
      chk("hold_result", rsp_result, 64'd105);
      chk("hold_eng_rst", 64'(eng_rst), 64'd1);
    end
    chk("hold_result_first", held_res, 64'd105);
    rsp_ready = 4'b0100;
    step();
    step();
    chk("hold_released", 64'(rsp_valid), 64'd0);
    chk("hold_idle", 64'(busy), 64'd0);
    rsp_ready = '1;

    // Engine never finishes: timeout after TO RUN cycles
    do_reset();
    stub_never = 1'b1;
    set_req(3, 9);
    run_jobs(1, 1'b0);
    chk("to_timeout", 64'(tout_q[0]), 64'd1);
    chk("to_result", res_q[0], 64'd0);
    chk("to_latency", 64'(lat_q[0]), 64'(TO));
    stub_never = 1'b0;

    // Done on the last RUN cycle beats the timeout
    stub_lat = TO - 1;
    set_req(1, 4);
    run_jobs(1, 1'b0);
    chk("tie_timeout", 64'(tout_q[1]), 64'd0);
    chk("tie_result", res_q[1], 64'd104);
    chk("tie_latency", 64'(lat_q[1]), 64'(TO));

    // Done already high on the first RUN cycle is ignored
    stub_lat = 0;
    set_req(0, 6);
    run_jobs(1, 1'b0);
    chk("early_done_result", res_q[2], 64'd106);
    chk("early_done_latency", 64'(lat_q[2]), 64'd2);
    stub_lat = -1;

    // Reset asserted mid-RUN
    set_req(0, 20);
    budget = 0;
    while (ack == '0 && budget < 50) begin step(); budget++; end
    req = '0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_eng_rst", 64'(eng_rst), 64'd1);
    chk("midrst_eng_n", 64'(eng_n), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    step(); step();
    rst = 1'b1;
    for (int j = 0; j < 30; j++) begin
      step();
      chk("midrst_no_stale", 64'(rsp_valid), 64'd0);
    end

    // Fibonacci-producing engine for every N
    clear_logs();
    stub_fib = 1'b1;
    stub_lat = 2;
    for (int n = 0; n < 32; n++) begin
      set_req(n % NR, n);
      run_jobs(1, 1'b0);
      chk("fib_result", res_q[n], fib(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
